instr_loader: RTL and testbench



---
 rtl/loader_pkg.sv | 18 +
 rtl/byte_packer.sv | 45 ++++
 rtl/instr_loader.sv | 180 ++++++++++++++++++
 tb/tb_instr_loader.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERROR
    } loader_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_BYTES      = 2;

endpackage

// File: rtl/byte_packer.sv
// Assembles little-endian words from a byte stream: lane byte_idx takes the next byte.
module byte_packer
    import loader_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int WORD_WIDTH = BYTES_PER_WORD * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] byte_in,
    output logic                  word_full,
    output logic [WORD_WIDTH-1:0] packed_word
);

    localparam int IDX_W = $clog2(BYTES_PER_WORD);

    logic [IDX_W-1:0]      idx_q;
    logic [WORD_WIDTH-1:0] word_q;

    // word_full flags that the next load completes the word.
    assign word_full = (idx_q == IDX_W'(BYTES_PER_WORD - 1));

    // packed_word already includes byte_in so the top can capture the word on the 4th byte.
    always_comb begin
        packed_word = word_q;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (idx_q == IDX_W'(i)) begin
                packed_word[i*DATA_WIDTH +: DATA_WIDTH] = byte_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            idx_q  <= '0;
            word_q <= '0;
        end else if (load) begin
            word_q <= packed_word;
            idx_q  <= word_full ? '0 : idx_q + IDX_W'(1);
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Program loader: takes a length-prefixed, checksummed byte stream and writes it to
// instruction memory, holding the CPU disabled until a verified image is in place.
module instr_loader
    import loader_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 8,
    parameter int                       WORD_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0,
    parameter int                       MAX_WORDS     = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     byte_valid,
    input  logic [DATA_WIDTH-1:0]    byte_data,
    output logic                     byte_ready,
    output logic                     wr_en,
    output logic [ADDRESS_WIDTH-1:0] wr_addr,
    output logic [WORD_WIDTH-1:0]    wr_data,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic                     cpu_en
);

    localparam int LEN_W = LEN_BYTES * DATA_WIDTH;

    // Handshake: a byte moves on a rising edge where byte_valid && byte_ready.
    // byte_ready depends only on state, so a waiting source just holds byte_valid/byte_data.

    loader_state_t state_q, state_d;

    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      word_idx_q;
    logic [DATA_WIDTH-1:0] csum_q;

    logic                  xfer;
    logic                  can_start;
    logic [LEN_W-1:0]      len_full;
    logic                  last_word;
    logic                  pk_clear;
    logic                  pk_load;
    logic                  word_full;
    logic [WORD_WIDTH-1:0] packed_word;

    assign xfer      = byte_valid && byte_ready;
    assign can_start = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
    assign len_full  = {byte_data, len_q[DATA_WIDTH-1:0]};
    assign last_word = (word_idx_q + LEN_W'(1)) == len_q;
    assign pk_clear  = can_start;
    assign pk_load   = (state_q == S_DATA) && xfer;

    byte_packer #(
        .DATA_WIDTH (DATA_WIDTH),
        .WORD_WIDTH (WORD_WIDTH)
    ) u_packer (
        .clk         (clk),
        .rst         (rst),
        .clear       (pk_clear),
        .load        (pk_load),
        .byte_in     (byte_data),
        .word_full   (word_full),
        .packed_word (packed_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        wr_en      = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                done  = (state_q == S_DONE);
                error = (state_q == S_ERROR);
                if (start) begin
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                busy       = 1'b1;
                byte_ready = 1'b1;
                if (xfer) begin
                    state_d = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                busy       = 1'b1;
                byte_ready = 1'b1;
                if (xfer) begin
                    if (int'(len_full) > MAX_WORDS) begin
                        state_d = S_ERROR;
                    end else if (len_full == '0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                busy       = 1'b1;
                byte_ready = 1'b1;
                if (xfer && word_full) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                busy = 1'b1;
                // A reset landing on the write cycle suppresses the strobe.
                wr_en   = !rst;
                state_d = last_word ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                busy       = 1'b1;
                byte_ready = 1'b1;
                if (xfer) begin
                    state_d = (byte_data == csum_q) ? S_DONE : S_ERROR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cpu_en = done;

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q      <= '0;
            word_idx_q <= '0;
            csum_q     <= '0;
            wr_addr    <= BASE_ADDR;
            wr_data    <= '0;
        end else begin
            if (can_start) begin
                len_q      <= '0;
                word_idx_q <= '0;
                csum_q     <= '0;
            end
            case (state_q)
                S_LEN_LO: begin
                    if (xfer) begin
                        len_q[DATA_WIDTH-1:0] <= byte_data;
                        csum_q                <= csum_q ^ byte_data;
                    end
                end
                S_LEN_HI: begin
                    if (xfer) begin
                        len_q  <= len_full;
                        csum_q <= csum_q ^ byte_data;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        csum_q <= csum_q ^ byte_data;
                        // Word and address are captured here so they are stable during WRITE.
                        if (word_full) begin
                            wr_data <= packed_word;
                            wr_addr <= BASE_ADDR + (ADDRESS_WIDTH'(word_idx_q) << 2);
                        end
                    end
                end
                S_WRITE: begin
                    word_idx_q <= word_idx_q + LEN_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: random byte streams built from word images, checked against
// a stream/image model of the expected writes and final status.
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_en;

    int total = 0;
    int bad   = 0;

    logic [31:0] img_words[$];
    logic [7:0]  tx_q[$];
    logic [63:0] exp_q[$];
    logic [63:0] obs_q[$];
    bit          exp_done;
    int          ready_viol = 0;

    instr_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .cpu_en     (cpu_en)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (wr_en) obs_q.push_back({wr_addr, wr_data});
        if (!rst && (byte_ready !== (busy && !wr_en))) ready_viol++;
    end

    // ---------------- model ----------------
    // Builds the byte stream and the expected (addr, data) writes for img_words.
    task automatic make_stream(input bit corrupt, input logic [7:0] bad_val);
        logic [7:0]  x;
        logic [31:0] n;
        logic [31:0] w;
        n = img_words.size();
        tx_q  = {};
        exp_q = {};
        tx_q.push_back(n[7:0]);
        tx_q.push_back(n[15:8]);
        x = n[7:0] ^ n[15:8];
        for (int i = 0; i < img_words.size(); i++) begin
            w = img_words[i];
            for (int b = 0; b < 4; b++) begin
                tx_q.push_back(w[8*b +: 8]);
                x = x ^ w[8*b +: 8];
            end
            exp_q.push_back({32'(4 * i), w});
        end
        if (corrupt) tx_q.push_back((bad_val == x) ? ~x : bad_val);
        else         tx_q.push_back(x);
        exp_done = !corrupt;
    endtask

    // ---------------- drivers ----------------
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Sends tx_q with random idle gaps; holds the byte while byte_ready is low.
    task automatic send_bytes(input int gap_pct);
        int budget;
        while (tx_q.size() > 0) begin
            if (int'($urandom_range(99)) < gap_pct) begin
                byte_valid = 1'b0;
                byte_data  = 8'($urandom);
                @(negedge clk);
                continue;
            end
            byte_valid = 1'b1;
            byte_data  = tx_q[0];
            budget = 0;
            while (!byte_ready && budget < 50) begin
                @(negedge clk);
                budget++;
            end
            if (!byte_ready) begin
                total++; bad++;
                $display("FAIL send_timeout: byte_ready stuck at %0b, want 1", byte_ready);
                tx_q = {};
                break;
            end
            @(negedge clk);
            void'(tx_q.pop_front());
        end
        byte_valid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        repeat (3) @(negedge clk);
        total++; if (byte_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %0b want 0", byte_ready); end
        total++; if (wr_en !== 1'b0)      begin bad++; $display("FAIL reset_wr_en: got %0b want 0", wr_en); end
        total++; if ({busy, done, error, cpu_en} !== 4'b0) begin bad++; $display("FAIL reset_status: got %b want 0000", {busy, done, error, cpu_en}); end
        total++; if (wr_addr !== 32'h0)   begin bad++; $display("FAIL reset_wr_addr: got %h want 0", wr_addr); end
        total++; if (wr_data !== 32'h0)   begin bad++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
        rst = 1'b0;
        @(negedge clk);
        total++; if ({busy, byte_ready} !== 2'b00) begin bad++; $display("FAIL idle_after_reset: got %b want 00", {busy, byte_ready}); end
    endtask

    // One full session for the current img_words; checks writes and final status.
    task automatic test_load(input string name, input bit do_start, input bit corrupt,
                             input logic [7:0] bad_val, input int gap_pct);
        int budget;
        make_stream(corrupt, bad_val);
        obs_q = {};
        ready_viol = 0;
        if (do_start) pulse_start();
        send_bytes(gap_pct);
        budget = 0;
        while (!(done || error) && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        total++; if (done !== exp_done)    begin bad++; $display("FAIL %s done: got %0b want %0b", name, done, exp_done); end
        total++; if (error !== !exp_done)  begin bad++; $display("FAIL %s error: got %0b want %0b", name, error, !exp_done); end
        total++; if (cpu_en !== exp_done)  begin bad++; $display("FAIL %s cpu_en: got %0b want %0b", name, cpu_en, exp_done); end
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL %s busy: got %0b want 0", name, busy); end
        total++; if (ready_viol !== 0)     begin bad++; $display("FAIL %s ready_rule: got %0d violations want 0", name, ready_viol); end
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++; $display("FAIL %s write_count: got %0d want %0d", name, obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                if (obs_q[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL %s write[%0d]: got addr=%h data=%h want addr=%h data=%h",
                             name, i, obs_q[i][63:32], obs_q[i][31:0], exp_q[i][63:32], exp_q[i][31:0]);
                    break;
                end
            end
        end
    endtask

    task automatic set_example_image();
        img_words = {32'h0050_0093, 32'h00A0_0113};
    endtask

    task automatic set_random_image(input int n);
        img_words = {};
        for (int i = 0; i < n; i++) img_words.push_back($urandom);
    endtask

    task automatic test_normal();
        set_example_image();
        test_load("normal", 1'b1, 1'b0, 8'h00, 0);
    endtask

    task automatic test_bad_checksum();
        set_example_image();
        test_load("bad_csum", 1'b1, 1'b1, 8'h00, 0);
    endtask

    task automatic test_zero_length();
        img_words = {};
        test_load("zero_len", 1'b1, 1'b0, 8'h00, 0);
    endtask

    task automatic test_too_long();
        obs_q = {};
        tx_q = {8'h01, 8'h01};
        pulse_start();
        send_bytes(0);
        total++; if (error !== 1'b1)      begin bad++; $display("FAIL too_long error: got %0b want 1", error); end
        total++; if (byte_ready !== 1'b0) begin bad++; $display("FAIL too_long ready: got %0b want 0", byte_ready); end
        total++; if ({busy, done, cpu_en} !== 3'b000) begin bad++; $display("FAIL too_long status: got %b want 000", {busy, done, cpu_en}); end
        total++; if (obs_q.size() != 0)   begin bad++; $display("FAIL too_long writes: got %0d want 0", obs_q.size()); end
    endtask

    task automatic test_max_len();
        set_random_image(256);
        test_load("max_len", 1'b1, 1'b0, 8'h00, 0);
    endtask

    task automatic test_backpressure();
        set_example_image();
        test_load("backpressure", 1'b1, 1'b0, 8'h00, 60);
    endtask

    task automatic test_reset_mid_word();
        set_example_image();
        make_stream(1'b0, 8'h00);
        while (tx_q.size() > 4) void'(tx_q.pop_back());
        obs_q = {};
        pulse_start();
        send_bytes(0);
        rst = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'hA5;
        @(negedge clk);
        rst = 1'b0;
        byte_valid = 1'b0;
        total++; if ({byte_ready, wr_en, busy, done, error, cpu_en} !== 6'b0) begin
            bad++; $display("FAIL rst_mid status: got %b want 000000", {byte_ready, wr_en, busy, done, error, cpu_en});
        end
        total++; if (wr_addr !== 32'h0 || wr_data !== 32'h0) begin
            bad++; $display("FAIL rst_mid wr_bus: got addr=%h data=%h want 0/0", wr_addr, wr_data);
        end
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL rst_mid writes: got %0d want 0", obs_q.size()); end
        set_random_image(3);
        test_load("after_rst", 1'b1, 1'b0, 8'h00, 20);
    endtask

    task automatic test_restart_ignore();
        logic [7:0] full_q[$];
        int budget;
        set_example_image();
        make_stream(1'b0, 8'h00);
        full_q = tx_q;
        tx_q = full_q[0:3];
        obs_q = {};
        ready_viol = 0;
        pulse_start();
        send_bytes(0);
        pulse_start();
        total++; if ({busy, byte_ready} !== 2'b11) begin bad++; $display("FAIL ignore_start status: got %b want 11", {busy, byte_ready}); end
        tx_q = full_q[4:$];
        send_bytes(30);
        budget = 0;
        while (!(done || error) && budget < 100) begin @(negedge clk); budget++; end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL ignore_start done: got %0b want 1", done); end
        total++; if (obs_q.size() != exp_q.size() || (obs_q.size() > 1 && (obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1]))) begin
            bad++; $display("FAIL ignore_start writes: got %0d writes, want %0d matching", obs_q.size(), exp_q.size());
        end
        pulse_start();
        total++; if ({done, cpu_en, busy} !== 3'b001) begin bad++; $display("FAIL restart_clear: got %b want 001", {done, cpu_en, busy}); end
        set_random_image(4);
        test_load("second_image", 1'b0, 1'b0, 8'h00, 25);
    endtask

    task automatic test_random();
        for (int r = 0; r < 5; r++) begin
            set_random_image(int'($urandom_range(1, 8)));
            test_load($sformatf("random%0d", r), 1'b1, ($urandom_range(3) == 0),
                      8'($urandom), int'($urandom_range(0, 70)));
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_bad_checksum();
        test_zero_length();
        test_too_long();
        test_backpressure();
        test_max_len();
        test_reset_mid_word();
        test_restart_ignore();
        test_random();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
